aes_dec_cntx: RTL and testbench

AES_DEC_CNTX -- requirements
Module: aes_dec_cntx

---
 rtl/aes_pkg.sv | 19 +
 rtl/aes_col_rnd_cnt.sv | 38 +++
 rtl/aes_dec_cntx.sv | 170 +++++++++++++++++
 tb/tb_aes_dec_cntx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and sizes for the AES decryption control slice.
package aes_pkg;

  localparam int NR    = 10;
  localparam int NCOL  = 4;
  localparam int COL_W = 2;
  localparam int RK_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_KEXP,
    S_INIT_ARK,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_t;

endpackage

// File: rtl/aes_col_rnd_cnt.sv
// Column counter with wrap pulse and a loadable up/down round counter.
module aes_col_rnd_cnt
  import aes_pkg::*;
#(
  parameter int NCOL = aes_pkg::NCOL
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            col_en,
  input  logic            rnd_ld,
  input  logic [RK_W-1:0] rnd_val,
  input  logic            rnd_up,
  input  logic            rnd_dn,
  output logic [COL_W-1:0] col,
  output logic            wrap,
  output logic [RK_W-1:0] rnd
);

  assign wrap = col_en && (col == COL_W'(NCOL - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      col <= '0;
      rnd <= '0;
    end else begin
      if (col_en)
        col <= wrap ? '0 : col + 1'b1;
      // round steps only land on a column wrap
      if (rnd_ld)
        rnd <= rnd_val;
      else if (wrap && rnd_up)
        rnd <= rnd + 1'b1;
      else if (wrap && rnd_dn)
        rnd <= rnd - 1'b1;
    end
  end

endmodule

// File: rtl/aes_dec_cntx.sv
// AES inverse-cipher sequencer: load, key expansion, rounds, done/ack.
// Optional key reuse cache enabled by AES_DEC_KEY_CACHE_EN.
module aes_dec_cntx
  import aes_pkg::*;
#(
  parameter int NCOL = aes_pkg::NCOL,
  parameter int NR   = aes_pkg::NR
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             key_reuse,
  input  logic             ack,
  output logic             ld_en,
  output logic             ks_run,
  output logic             ks_we,
  output logic [RK_W-1:0]  rk_addr,
  output logic [RK_W-1:0]  rnd_no,
  output logic             skip_imix,
  output logic [COL_W-1:0] col,
  output logic             busy,
  output logic             done
);

  state_t state_q;
  state_t state_d;

  logic            col_en;
  logic            wrap;
  logic            rnd_ld;
  logic [RK_W-1:0] rnd_val;
  logic            rnd_up;
  logic            rnd_dn;
  logic [RK_W-1:0] rnd;
  logic            kv_set;
  logic            skip_q;
  logic            skip_d;

  aes_col_rnd_cnt #(
    .NCOL(NCOL)
  ) u_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .col_en (col_en),
    .rnd_ld (rnd_ld),
    .rnd_val(rnd_val),
    .rnd_up (rnd_up),
    .rnd_dn (rnd_dn),
    .col    (col),
    .wrap   (wrap),
    .rnd    (rnd)
  );

`ifdef AES_DEC_KEY_CACHE_EN
  logic key_valid;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      key_valid <= 1'b0;
      skip_q    <= 1'b0;
    end else begin
      if (kv_set)
        key_valid <= 1'b1;
      skip_q <= skip_d;
    end
  end

  assign skip_d = (state_q == S_IDLE)
                ? (start && key_reuse && key_valid)
                : skip_q;
`else
  logic unused_key;

  assign unused_key = key_reuse ^ kv_set;
  assign skip_d     = 1'b0;
  assign skip_q     = skip_d;
`endif

  always_ff @(posedge clk) begin
    if (!rstn)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    col_en  = 1'b0;
    rnd_ld  = 1'b0;
    rnd_val = '0;
    rnd_up  = 1'b0;
    rnd_dn  = 1'b0;
    kv_set  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          rnd_ld  = 1'b1;
        end
      end
      S_LOAD: begin
        col_en = 1'b1;
        if (wrap) begin
          rnd_ld = 1'b1;
          if (skip_q) begin
            state_d = S_INIT_ARK;
            rnd_val = RK_W'(NR);
          end else begin
            state_d = S_KEXP;
            rnd_val = RK_W'(1);
          end
        end
      end
      S_KEXP: begin
        col_en = 1'b1;
        if (wrap) begin
          if (rnd == RK_W'(NR)) begin
            state_d = S_INIT_ARK;
            kv_set  = 1'b1;
          end else begin
            rnd_up = 1'b1;
          end
        end
      end
      S_INIT_ARK: begin
        col_en = 1'b1;
        if (wrap) begin
          state_d = S_ROUND;
          rnd_ld  = 1'b1;
          rnd_val = RK_W'(NR - 1);
        end
      end
      S_ROUND: begin
        col_en = 1'b1;
        if (wrap) begin
          if (rnd == RK_W'(1)) begin
            state_d = S_FINAL;
            rnd_ld  = 1'b1;
          end else begin
            rnd_dn = 1'b1;
          end
        end
      end
      S_FINAL: begin
        col_en = 1'b1;
        if (wrap)
          state_d = S_DONE;
      end
      S_DONE: begin
        if (ack)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // every output decodes registered state only
  assign ld_en     = (state_q == S_LOAD);
  assign ks_run    = (state_q == S_KEXP);
  assign ks_we     = ((state_q == S_LOAD) && !skip_q) ||
                     ((state_q == S_KEXP) && (col == COL_W'(NCOL - 1)));
  assign skip_imix = (state_q == S_INIT_ARK) || (state_q == S_FINAL);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign rk_addr   = rnd;
  assign rnd_no    = ((state_q == S_INIT_ARK) ||
                      (state_q == S_ROUND) ||
                      (state_q == S_FINAL)) ? rnd : '0;

endmodule

// File: tb/tb_aes_dec_cntx.sv
// Directed scoreboard bench for the AES decryption sequencer.
module tb_aes_dec_cntx;

  localparam int TNR   = 10;
  localparam int TNCOL = 4;

  typedef logic [15:0] vec_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic       key_reuse;
  logic       ack;
  logic       ld_en;
  logic       ks_run;
  logic       ks_we;
  logic [3:0] rk_addr;
  logic [3:0] rnd_no;
  logic       skip_imix;
  logic [1:0] col;
  logic       busy;
  logic       done;

  int   checks = 0;
  int   errors = 0;
  int   lat;
  vec_t sb[$];

  always #5 clk = ~clk;

  aes_dec_cntx dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .key_reuse(key_reuse),
    .ack      (ack),
    .ld_en    (ld_en),
    .ks_run   (ks_run),
    .ks_we    (ks_we),
    .rk_addr  (rk_addr),
    .rnd_no   (rnd_no),
    .skip_imix(skip_imix),
    .col      (col),
    .busy     (busy),
    .done     (done)
  );

  vec_t obs;
  assign obs = {ld_en, ks_run, ks_we, skip_imix, busy, done,
                rk_addr, rnd_no, col};

  function automatic vec_t mk(bit l, bit r, bit w, bit s, bit b, bit d,
                              int rk, int rn, int c);
    vec_t v;
    v = {l, r, w, s, b, d, 4'(rk), 4'(rn), 2'(c)};
    return v;
  endfunction

  localparam vec_t V_IDLE = 16'h0000;
  localparam vec_t V_DONE = 16'h0C00;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input vec_t e);
    checks++;
    assert (obs === e)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic chk_int(input string tag, input int o, input int e);
    checks++;
    assert (o === e)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic push_trace(input bit skip);
    for (int c = 0; c < TNCOL; c++)
      sb.push_back(mk(1, 0, !skip, 0, 1, 0, 0, 0, c));
    if (!skip)
      for (int r = 1; r <= TNR; r++)
        for (int c = 0; c < TNCOL; c++)
          sb.push_back(mk(0, 1, c == TNCOL - 1, 0, 1, 0, r, 0, c));
    for (int c = 0; c < TNCOL; c++)
      sb.push_back(mk(0, 0, 0, 1, 1, 0, TNR, TNR, c));
    for (int r = TNR - 1; r >= 1; r--)
      for (int c = 0; c < TNCOL; c++)
        sb.push_back(mk(0, 0, 0, 0, 1, 0, r, r, c));
    for (int c = 0; c < TNCOL; c++)
      sb.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, c));
    sb.push_back(V_DONE);
  endtask

  task automatic run_op(input logic reuse, input int stop_at,
                        input bit inject, output int l);
    vec_t e;
    l         = -1;
    start     = 1'b1;
    key_reuse = reuse;
    for (int i = 0; i < stop_at && sb.size() > 0; i++) begin
      step();
      start     = 1'b0;
      key_reuse = 1'b0;
      e = sb.pop_front();
      chk($sformatf("op_cyc%0d", i), e);
      if (inject) begin
        start = (i == 9) || (i == 49);
        ack   = (i == 59);
      end
      if (e[10]) begin
        l = i;
        break;
      end
    end
    start = 1'b0;
    ack   = 1'b0;
  endtask

  task automatic release_done();
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("ack_to_idle", V_IDLE);
  endtask

  initial begin
    rstn      = 1'b0;
    start     = 1'b1;
    key_reuse = 1'b0;
    ack       = 1'b1;
    step();
    step();
    chk("reset_prio", V_IDLE);
    start = 1'b0;
    ack   = 1'b0;
    rstn  = 1'b1;
    step();
    chk("idle_hold", V_IDLE);

    // op1: full path with ignored start/ack pulses
    push_trace(1'b0);
    run_op(1'b0, 200, 1'b1, lat);
    chk_int("lat_full1", lat, 88);

    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("done_hold%0d", i), V_DONE);
    end
    ack   = 1'b1;
    start = 1'b1;
    step();
    chk("ack_start_idle", V_IDLE);
    ack   = 1'b0;
    start = 1'b0;
    step();
    chk("start_not_taken", V_IDLE);

    // op2: key reuse request
`ifdef AES_DEC_KEY_CACHE_EN
    push_trace(1'b1);
    run_op(1'b1, 200, 1'b0, lat);
    chk_int("lat_reuse", lat, 48);
`else
    push_trace(1'b0);
    run_op(1'b1, 200, 1'b0, lat);
    chk_int("lat_reuse_off", lat, 88);
`endif
    release_done();

    // op3: reset mid-ROUND
    push_trace(1'b0);
    run_op(1'b0, 60, 1'b0, lat);
    sb.delete();
    rstn = 1'b0;
    step();
    chk("reset_mid_round", V_IDLE);
    rstn = 1'b1;
    step();
    chk("idle_after_reset", V_IDLE);

    // op4: reuse after reset must take the full path
    push_trace(1'b0);
    run_op(1'b1, 200, 1'b0, lat);
    chk_int("lat_after_reset", lat, 88);
    release_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
